// File: rtl/seg_dp_reducer.sv
// Segmented least-squares DP: folds Emin(j,i) beats into OPT(i)/argmin per row, then backtraces stored segment starts.
// Latency: row_done 1 cycle after the final beat; trace emits one segment per cycle. No backpressure, so beats are taken every cycle.
module seg_dp_reducer #(
  parameter int                          BIT_WIDTH = 32,
  parameter int                          I         = 160,
  parameter logic signed [BIT_WIDTH-1:0] PENALTY   = 32'sd4096,
  parameter int                          IW        = $clog2(I)
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        row_start,
  input  logic [IW-1:0]               row_i,
  input  logic                        emin_valid,
  input  logic [IW-1:0]               emin_j,
  input  logic signed [BIT_WIDTH-1:0] emin_data,
  input  logic                        trace_start,
  input  logic [IW-1:0]               trace_i,
  output logic                        busy,
  output logic                        row_done,
  output logic signed [BIT_WIDTH-1:0] opt_out,
  output logic [IW-1:0]               argmin_out,
  output logic                        seg_valid,
  output logic [IW-1:0]               seg_lo,
  output logic [IW-1:0]               seg_hi,
  output logic                        trace_done,
  output logic                        err
);

  localparam int CW = BIT_WIDTH + 2;
  localparam logic signed [BIT_WIDTH-1:0] VMAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic signed [BIT_WIDTH-1:0] VMIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};
  localparam logic signed [CW-1:0]        CMAX = CW'(VMAX);
  localparam logic signed [CW-1:0]        CMIN = CW'(VMIN);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_TRACE} state_t;

  state_t r_state, w_state_nxt;

  logic signed [BIT_WIDTH-1:0] r_opt_mem   [0:I-1];
  logic [IW-1:0]               r_start_mem [0:I-1];

  logic [IW:0]                 r_rows_filled;
  logic [IW-1:0]               r_row_i, r_expect_j, r_hi, r_best_j;
  logic signed [BIT_WIDTH-1:0] r_best_val;
  logic                        r_row_done, r_trace_done, r_err;
  logic signed [BIT_WIDTH-1:0] r_opt_out;
  logic [IW-1:0]               r_argmin_out;

  logic                        w_row_ok, w_trace_ok, w_beat, w_beat_ok, w_last;
  logic [IW-1:0]               w_jm1, w_min_j, w_seg_lo_raw;
  logic signed [BIT_WIDTH-1:0] w_prev, w_cand, w_min_val;
  logic signed [CW-1:0]        w_cand_wide;
  logic                        w_take, w_corrupt, w_seg_first, w_trace_end;

  // A row is accepted only in order and only while there is still room in the tables.
  assign w_row_ok   = ({1'b0, row_i} == r_rows_filled) && (r_rows_filled < (IW+1)'(I));
  assign w_trace_ok = ({1'b0, trace_i} < r_rows_filled);
  assign w_beat     = (r_state == S_ACCUM) && emin_valid;
  assign w_beat_ok  = w_beat && (emin_j == r_expect_j);
  assign w_last     = w_beat_ok && (emin_j == r_row_i);

  // Extra headroom bits let the three-term sum be clamped instead of wrapping.
  assign w_jm1       = emin_j - IW'(1);
  assign w_prev      = (emin_j == '0) ? '0 : r_opt_mem[w_jm1];
  assign w_cand_wide = CW'(w_prev) + CW'(emin_data) + CW'(PENALTY);
  assign w_cand      = (w_cand_wide > CMAX) ? VMAX :
                       (w_cand_wide < CMIN) ? VMIN : w_cand_wide[BIT_WIDTH-1:0];
  assign w_take      = (w_cand < r_best_val);
  assign w_min_val   = w_take ? w_cand : r_best_val;
  assign w_min_j     = w_take ? emin_j : r_best_j;

  assign w_seg_lo_raw = r_start_mem[r_hi];
  assign w_corrupt    = (w_seg_lo_raw > r_hi);
  assign w_seg_first  = (w_seg_lo_raw == '0);
  assign w_trace_end  = (r_state == S_TRACE) && (w_corrupt || w_seg_first);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (row_start) begin
          if (w_row_ok) w_state_nxt = S_ACCUM;
        end else if (trace_start && w_trace_ok) begin
          w_state_nxt = S_TRACE;
        end
      end
      S_ACCUM: if (w_last)      w_state_nxt = S_IDLE;
      S_TRACE: if (w_trace_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rows_filled <= '0;
      r_row_i       <= '0;
      r_expect_j    <= '0;
      r_hi          <= '0;
      r_best_val    <= VMAX;
      r_best_j      <= '0;
      r_row_done    <= 1'b0;
      r_trace_done  <= 1'b0;
      r_err         <= 1'b0;
      r_opt_out     <= '0;
      r_argmin_out  <= '0;
    end else begin
      r_row_done   <= 1'b0;
      r_trace_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (row_start) begin
            if (w_row_ok) begin
              r_row_i    <= row_i;
              r_best_val <= VMAX;
              r_best_j   <= '0;
              r_expect_j <= '0;
            end else begin
              r_err <= 1'b1;
            end
          end else if (trace_start) begin
            if (w_trace_ok) r_hi  <= trace_i;
            else            r_err <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (w_beat && !w_beat_ok) begin
            r_err <= 1'b1;
          end else if (w_beat_ok) begin
            r_best_val <= w_min_val;
            r_best_j   <= w_min_j;
            r_expect_j <= r_expect_j + IW'(1);
            if (w_last) begin
              r_rows_filled <= r_rows_filled + (IW+1)'(1);
              r_row_done    <= 1'b1;
              r_opt_out     <= w_min_val;
              r_argmin_out  <= w_min_j;
            end
          end
        end
        S_TRACE: begin
          if (w_corrupt) begin
            r_err        <= 1'b1;
            r_trace_done <= 1'b1;
          end else if (w_seg_first) begin
            r_trace_done <= 1'b1;
          end else begin
            r_hi <= w_seg_lo_raw - IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Tables are deliberately not reset; rows_filled alone says which entries are trusted.
  always_ff @(posedge clk_in) begin
    if (w_last) begin
      r_opt_mem[r_row_i]   <= w_min_val;
      r_start_mem[r_row_i] <= w_min_j;
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign row_done   = r_row_done;
  assign opt_out    = r_opt_out;
  assign argmin_out = r_argmin_out;
  assign trace_done = r_trace_done;
  assign err        = r_err;
  assign seg_valid  = (r_state == S_TRACE) && !w_corrupt;
  assign seg_lo     = seg_valid ? w_seg_lo_raw : '0;
  assign seg_hi     = seg_valid ? r_hi : '0;

endmodule
